// File: rtl/seq_divider_if.sv
// Handshake bundle for seq_divider: operand request channel and result channel.
// master drives operands and out_ready; slave is the divider itself.
interface seq_divider_if #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, MSB first.
// Results land in dedicated output registers one cycle after the last iteration.
module seq_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(DIVIDEND_W);
    localparam logic [CW-1:0] CNT_INIT = CW'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W-1:0]  part_q, part_d;
    logic [DIVIDEND_W-1:0] qw_q, qw_d;
    logic                  dbz_w_q, dbz_w_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  div_by_zero_q, div_by_zero_d;

    logic [DIVISOR_W:0]    trial, diff;
    logic                  ge;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dvd_d         = dvd_q;
        dvs_d         = dvs_q;
        part_d        = part_q;
        qw_d          = qw_q;
        dbz_w_d       = dbz_w_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        // Partial remainder stays below the divisor, so the difference fits back in DIVISOR_W bits.
        trial = {part_q, dvd_q[cnt_q]};
        diff  = trial - {1'b0, dvs_q};
        ge    = (trial >= {1'b0, dvs_q});

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    dvd_d      = bus.dividend;
                    dvs_d      = bus.divisor;
                    part_d     = '0;
                    cnt_d      = CNT_INIT;
                    in_ready_d = 1'b0;
                    if (bus.divisor == '0) begin
                        qw_d    = '1;
                        dbz_w_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        qw_d    = '0;
                        dbz_w_d = 1'b0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                part_d      = ge ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
                qw_d[cnt_q] = ge;
                cnt_d       = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = DONE;
            end
            DONE: begin
                if (!out_valid_q) begin
                    quotient_d    = qw_q;
                    remainder_d   = part_q;
                    div_by_zero_d = dbz_w_q;
                    out_valid_d   = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dvd_q         <= '0;
            dvs_q         <= '0;
            part_q        <= '0;
            qw_q          <= '0;
            dbz_w_q       <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dvd_q         <= dvd_d;
            dvs_q         <= dvs_d;
            part_q        <= part_d;
            qw_q          <= qw_d;
            dbz_w_q       <= dbz_w_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes expected results, a negedge
// monitor pops and compares on every result handshake.
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_divider_if #(.DIVIDEND_W(8), .DIVISOR_W(4)) bus ();

    seq_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        bit z;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    bit or_rand = 1'b0;
    bit or_val  = 1'b1;
    bit rnd_rdy = 1'b1;
    assign bus.out_ready = or_rand ? rnd_rdy : or_val;

    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(3) != 0);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic fail_now(input string nm);
        total_cnt++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // Monitor: one comparison set per result handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_result: got q=%0d r=%0d, expected no result",
                         bus.quotient, bus.remainder);
            end else begin
                e = sb.pop_front();
                chk($sformatf("quotient %0d/%0d", e.a, e.b), bus.quotient, e.q);
                chk($sformatf("remainder %0d/%0d", e.a, e.b), bus.remainder, e.r);
                chk($sformatf("div_by_zero %0d/%0d", e.a, e.b), bus.div_by_zero, e.z);
                if (e.b != 0) begin
                    chk($sformatf("invariant %0d/%0d", e.a, e.b),
                        int'(bus.quotient) * e.b + int'(bus.remainder), e.a);
                    chk($sformatf("rem_lt_div %0d/%0d", e.a, e.b),
                        longint'(int'(bus.remainder) < e.b), 1);
                end
            end
        end
    end

    // Called at posedge+1; returns at accept edge+1.
    task automatic issue(input int a, input int b, input int q, input int r,
                         input bit z, input bit push);
        int w = 0;
        while (!bus.in_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        if (!bus.in_ready) begin
            fail_now("accept_wait");
            return;
        end
        bus.in_valid = 1'b1;
        bus.dividend = 8'(a);
        bus.divisor  = 4'(b);
        if (push) sb.push_back('{a: a, b: b, q: q, r: r, z: z});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.out_valid) fail_now("out_valid_wait");
    endtask

    task automatic run(input int a, input int b, input int q, input int r, input bit z);
        int n;
        issue(a, b, q, r, z, 1'b1);
        wait_valid(n);
        chk($sformatf("latency %0d/%0d", a, b), n, (b == 0) ? 1 : 9);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int w;
        bus.in_valid = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_div_by_zero", bus.div_by_zero, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic op with latency and ready turnaround
        issue(200, 7, 28, 4, 1'b0, 1'b1);
        chk("busy_in_ready", bus.in_ready, 0);
        wait_valid(n);
        chk("latency_200_7", n, 9);
        @(posedge clk); #1;
        chk("in_ready_after_hs", bus.in_ready, 1);
        chk("out_valid_after_hs", bus.out_valid, 0);
        chk("hold_after_hs", bus.quotient, 28);

        run(255, 1, 255, 0, 1'b0);
        run(5, 9, 0, 5, 1'b0);
        run(0, 3, 0, 0, 1'b0);
        run(255, 15, 17, 0, 1'b0);
        run(100, 0, 255, 0, 1'b1);
        run(100, 3, 33, 1, 1'b0);

        // Backpressure with ignored in_valid pulses
        or_val = 1'b0;
        issue(200, 7, 28, 4, 1'b0, 1'b1);
        wait_valid(n);
        chk("bp_latency", n, 9);
        for (int i = 0; i < 5; i++) begin
            chk("bp_quotient", bus.quotient, 28);
            chk("bp_remainder", bus.remainder, 4);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            bus.in_valid = (i % 2 == 0);
            bus.dividend = 8'd9;
            bus.divisor  = 4'd3;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        or_val = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after_hs", bus.in_ready, 1);

        // Reset during BUSY aborts without a result
        issue(200, 7, 0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_quotient", bus.quotient, 0);
        chk("abort_remainder", bus.remainder, 0);
        chk("abort_div_by_zero", bus.div_by_zero, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run(81, 9, 9, 0, 1'b0);

        // All operand pairs with random result stalls
        or_rand = 1'b1;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(a, b, (b != 0) ? a / b : 255, (b != 0) ? a % b : 0, b == 0, 1'b1);
            end
        end
        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(posedge clk); #1; w++;
        end
        if (sb.size() != 0) fail_now("drain_scoreboard");
        or_rand = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned restoring divider; the inverse operation of the team's 4x4 array multiplier.
- Takes a DIVIDEND_W-bit dividend and a DIVISOR_W-bit divisor and produces the quotient and remainder, one quotient bit per clock.
- Uses a valid/ready handshake on both input and output so it can sit behind the multiplier datapath, or stand alone for quotient/remainder checks of `result = a*b`.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width (>=2).
- DIVISOR_W, 4, divisor and remainder width (>=1, <= DIVIDEND_W).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  dividend/divisor present.
- in_ready  output  1  block can accept an operation.
- dividend  input  DIVIDEND_W  unsigned dividend.
- divisor  input  DIVISOR_W  unsigned divisor.
- out_valid  output  1  result registers valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  DIVIDEND_W  unsigned quotient.
- remainder  output  DIVISOR_W  unsigned remainder.
- div_by_zero  output  1  divisor was zero for this result.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0; internal counter and partial remainder cleared.
- Reset asserted mid-operation aborts the operation immediately; no result is produced.
- States: IDLE, BUSY, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE:
  - On in_valid&in_ready, capture dividend and divisor.
  - If divisor==0: go to DONE next cycle with quotient={DIVIDEND_W{1}}, remainder=0, div_by_zero=1.
  - Otherwise: go to BUSY, partial remainder=0, counter=DIVIDEND_W-1.
- BUSY, one iteration per cycle, MSB first:
  - trial = {partial[DIVISOR_W-1:0], dividend bit[counter]}, DIVISOR_W+1 bits wide.
  - If trial >= divisor: partial = trial-divisor, quotient bit=1. Else: partial = trial, quotient bit=0.
  - Counter decrements; after the counter==0 iteration, go to DONE.
- Latency: accept edge to out_valid rising = DIVIDEND_W+1 cycles (9 for defaults). Divide-by-zero = 1 cycle.
- DONE:
  - quotient, remainder and div_by_zero are held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready, go to IDLE; out_valid deasserts next cycle; outputs keep their last values.
- No back-to-back overlap: a new operation is accepted no earlier than the cycle after the result handshake.
- in_valid while not in_ready is ignored. Input data only needs to be stable on the accept edge.
- Arithmetic invariant, always: dividend == quotient*divisor + remainder, and remainder < divisor (divisor != 0).

Test Plan:
- Dividend=200, divisor=7, out_ready=1 -> out_valid 9 cycles after accept; quotient=28, remainder=4, div_by_zero=0; in_ready returns 1 the cycle after the handshake.
- Boundaries:
  - 255/1 -> quotient=255, remainder=0.
  - 5/9 -> quotient=0, remainder=5.
  - 0/3 -> quotient=0, remainder=0.
  - 255/15 -> quotient=17, remainder=0.
- Dividend=100, divisor=0 -> out_valid 1 cycle after accept; quotient=255, remainder=0, div_by_zero=1; the next op 100/3 gives 33 r1 with div_by_zero=0.
- Backpressure: 200/7 with out_ready=0 for 5 cycles after out_valid -> outputs stable at 28/4, in_ready=0 throughout, in_valid pulses ignored; out_ready=1 completes the handshake.
- Reset mid-operation:
  - rst_n low at cycle 4 of BUSY -> all outputs immediately at reset values.
  - After release, 81/9 -> quotient=9, remainder=0 with normal latency.
- Exhaustive random: all 256x16 pairs with random out_ready stalls -> invariant holds for every nonzero divisor, and div_by_zero matches divisor==0.
